// File: rtl/sram_c_drain.sv
// Read-side drain controller for result buffer C: streams LEN bytes from a base
// address through a 2-entry skid FIFO. Build option: SRAMC_CLEAR_ON_READ_EN (zero each location as it is read).
module sram_c_drain #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a beat transfers on a rising edge where m_valid & m_ready;
    // m_data/m_last hold while m_valid & !m_ready, and m_valid never drops without a transfer.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    reads_left_q, reads_left_d;
    logic [LEN_W-1:0]    beats_left_q, beats_left_d;
    logic                inflight_q;
    logic [DATA_W-1:0]   fifo_mem_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          count_q, count_d;

    logic [LEN_W-1:0]    len_clamped;
    logic                push;
    logic                pop;
    logic [2:0]          occupancy;
    logic                issue;
    logic                fifo_empty_next;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = fifo_mem_q[rd_ptr_q];
    assign m_last  = m_valid && (beats_left_q == LEN_W'(1));
    assign push    = inflight_q;
    assign pop     = m_valid && m_ready;

    // Slots already claimed after this cycle's pop: FIFO entries plus the read in flight.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ST_ISSUE) && (reads_left_q != '0) && (occupancy < 3'd2);

    assign fifo_empty_next = (count_q == 2'd0) || ((count_q == 2'd1) && pop);

    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_FIN);
    assign sram_ce   = issue;
    assign sram_addr = addr_q;
    assign sram_din  = '0;
    assign dbg_state = state_q;

`ifdef SRAMC_CLEAR_ON_READ_EN
    assign sram_we = issue;
`else
    assign sram_we = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        reads_left_d = reads_left_q;
        beats_left_d = beats_left_q;

        if (pop && (beats_left_q != '0)) begin
            beats_left_d = beats_left_q - LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    reads_left_d = len_clamped;
                    beats_left_d = len_clamped;
                    state_d      = (len_clamped == '0) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    reads_left_d = reads_left_q - LEN_W'(1);
                    if (reads_left_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as the final beat is taken so done follows it by one cycle.
                if (!inflight_q && fifo_empty_next && (beats_left_d == '0)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            reads_left_q <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            reads_left_q <= reads_left_d;
            beats_left_q <= beats_left_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            inflight_q <= issue;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= sram_dout;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: doc/sram_c_drain.md
Name: sram_c_drain

Overview:
- Read-side controller for the 1024x8 result buffer C.
- On a start command, it streams LEN bytes from a base address out of the buffer, in address order.
- Output is a valid/ready byte stream toward the host/DMA side.
- It hides the buffer's 1-cycle registered read latency behind a 2-entry skid FIFO.
- It sustains 1 byte/clk under continuous ready.

Parameters:
- ADDR_W, 10, buffer address width; depth = 2**ADDR_W.
- DATA_W, 8, buffer/stream data width.
- LEN_W, 11, width of the length field; must hold 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first buffer address to read
- len  in  LEN_W  bytes to transfer; 0 = empty job; values >2**ADDR_W clamped to 2**ADDR_W
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  1-cycle pulse at job end
- sram_ce  out  1  buffer chip enable
- sram_we  out  1  buffer write enable (0 unless feature enabled)
- sram_addr  out  ADDR_W  buffer address
- sram_din  out  DATA_W  buffer write data (all zero)
- sram_dout  in  DATA_W  buffer read data; valid the cycle after ce
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  DATA_W  stream byte
- m_last  out  1  high with the final byte of the job

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - busy=0, done=0, sram_ce=0, sram_we=0, m_valid=0, m_last=0, m_data=0.
  - FIFO emptied, in-flight flag cleared, FSM to IDLE.
  - Applies mid-job: the job is abandoned, with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 latches base_addr, the clamped len and a beat counter, then moves to:
  - FIN if len==0;
  - ISSUE otherwise.
- ISSUE:
  - sram_ce is combinational and asserted when reads_left>0 and (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready.
  - Each issued read increments the address modulo 2**ADDR_W (wrap 1023→0 is legal) and decrements reads_left.
  - inflight register = sram_ce of the previous cycle.
  - When the last read issues, go to DRAIN.
- DRAIN: wait until the FIFO is empty, inflight=0, and the final beat has been accepted; then go to FIN.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- busy timing: busy=1 in ISSUE and DRAIN; 0 in IDLE and FIN.
- start while busy is ignored.
- FIFO rules:
  - Returning data (inflight=1) is pushed from sram_dout the cycle after ce.
  - FIFO head drives m_data; m_valid = fifo not empty.
  - Simultaneous push and pop is allowed at any count.
  - The issue rule above guarantees the FIFO never overflows.
- Stream rules:
  - m_data/m_last are held stable while m_valid & !m_ready.
  - m_last = (beats_remaining==1) on the head beat.
- Latency: start accepted at edge T; first ce in cycle T+1; first m_valid at T+3 (registered FIFO output).
- Throughput: with m_ready held high, one beat every cycle after the first.
- Arithmetic: beat counters are LEN_W wide and never underflow.

Optional Feature:
- Macro: SRAMC_CLEAR_ON_READ_EN.
- When defined:
  - Every issued read also drives sram_we=1 and sram_din=0 at the same address.
  - The buffer's read-before-write returns the old byte, so each drained location becomes zero.
  - This readies the buffer for the next accumulation pass with no extra cycles.
- When undefined: sram_we is tied 0 and the buffer contents are unchanged.

Test Plan:
- Buffer preloaded mem[i]=i&0xFF; base=0x010, len=4, m_ready=1 → bytes 10,11,12,13 on consecutive cycles; m_last with 13; done one cycle after the last beat; exactly 4 ce pulses.
- Wrap: base=0x3FE, len=4 → addresses 3FE,3FF,000,001; data FE,FF,00,01.
- Backpressure: len=8, m_ready toggled 1,0,0,1 pattern → all 8 bytes delivered in order, none duplicated; m_data stable while stalled; FIFO count never exceeds 2.
- len=0 → done pulses the cycle after start; no ce and no m_valid. len=2000 → exactly 1024 beats.
- Reset mid-job: rst_n low for 1 cycle after beat 3 of len=16 → next cycle all outputs 0 and no done pulse; a new start runs cleanly.
- With SRAMC_CLEAR_ON_READ_EN: drain base=0 len=16, then repeat the same job → second pass returns all 0x00; a second start issued while busy is ignored.
